// File: rtl/scr1_tcm_dport_arb_if.sv
`default_nettype none
// ============================================================================
// Module  : scr1_tcm_dport_arb_if
// Brief   : Bundle of requester (dmem, ext) and TCM port-B signals for the arbiter.
// Revision: 1.0
// ============================================================================
interface scr1_tcm_dport_arb_if #(
  parameter int AW = 16
);
  logic          dmem_req;
  logic          dmem_we;
  logic [1:0]    dmem_width;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata;
  logic          dmem_ack;
  logic          dmem_resp;
  logic          dmem_err;
  logic [31:0]   dmem_rdata;

  logic          ext_req;
  logic          ext_we;
  logic [1:0]    ext_width;
  logic [AW-1:0] ext_addr;
  logic [31:0]   ext_wdata;
  logic          ext_ack;
  logic          ext_resp;
  logic          ext_err;
  logic [31:0]   ext_rdata;

  logic          mem_renb;
  logic          mem_wenb;
  logic [3:0]    mem_webb;
  logic [AW-3:0] mem_addrb;
  logic [31:0]   mem_datab;
  logic [31:0]   mem_qb;

  // Environment side: both requesters plus the memory model.
  modport master (
    output dmem_req, dmem_we, dmem_width, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_resp, dmem_err, dmem_rdata,
    output ext_req, ext_we, ext_width, ext_addr, ext_wdata,
    input  ext_ack, ext_resp, ext_err, ext_rdata,
    input  mem_renb, mem_wenb, mem_webb, mem_addrb, mem_datab,
    output mem_qb
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_width, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_resp, dmem_err, dmem_rdata,
    input  ext_req, ext_we, ext_width, ext_addr, ext_wdata,
    output ext_ack, ext_resp, ext_err, ext_rdata,
    output mem_renb, mem_wenb, mem_webb, mem_addrb, mem_datab,
    input  mem_qb
  );
endinterface
`default_nettype wire

// File: rtl/scr1_tcm_dport_arb.sv
`default_nettype none
// ============================================================================
// Module  : scr1_tcm_dport_arb
// Brief   : TCM port-B arbiter for dmem/ext; optional anti-starvation via
//           SCR1_TCM_ARB_STARVE_EN.
// Revision: 1.0
// ============================================================================
module scr1_tcm_dport_arb #(
  parameter int TCM_SIZE     = 32'h00010000,
  parameter int STARVE_LIMIT = 4
) (
  input wire                  clk,
  input wire                  rst,
  scr1_tcm_dport_arb_if.slave bus
);
  localparam int AW = $clog2(TCM_SIZE);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DMEM = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  logic          w_ext_prio;
  logic          w_dmem_gnt;
  logic          w_ext_gnt;
  logic          w_any_gnt;
  logic          w_sel_we;
  logic [1:0]    w_sel_width;
  logic [AW-1:0] w_sel_addr;
  logic [31:0]   w_sel_wdata;
  logic          w_misalign;
  logic [3:0]    w_webb;
  logic [31:0]   w_datab;
  logic          w_dmem_rsp;
  logic          w_ext_rsp;
  logic [31:0]   w_rsp_data;

  owner_e        r_owner;
  logic          r_err;
  logic          r_rd;

  assign w_dmem_gnt = !rst && bus.dmem_req && !(w_ext_prio && bus.ext_req);
  assign w_ext_gnt  = !rst && bus.ext_req && !w_dmem_gnt;
  assign w_any_gnt  = w_dmem_gnt || w_ext_gnt;

  assign w_sel_we    = w_ext_gnt ? bus.ext_we    : bus.dmem_we;
  assign w_sel_width = w_ext_gnt ? bus.ext_width : bus.dmem_width;
  assign w_sel_addr  = w_ext_gnt ? bus.ext_addr  : bus.dmem_addr;
  assign w_sel_wdata = w_ext_gnt ? bus.ext_wdata : bus.dmem_wdata;

  always_comb begin
    w_misalign = 1'b0;
    w_webb     = 4'b1111;
    w_datab    = w_sel_wdata;
    case (w_sel_width)
      2'b00: begin
        w_webb  = 4'b0001 << w_sel_addr[1:0];
        w_datab = {4{w_sel_wdata[7:0]}};
      end
      2'b01: begin
        w_misalign = w_sel_addr[0];
        w_webb     = 4'b0011 << w_sel_addr[1:0];
        w_datab    = {2{w_sel_wdata[15:0]}};
      end
      2'b10:   w_misalign = |w_sel_addr[1:0];
      default: w_misalign = 1'b1;
    endcase
  end

  // Faulty requests are still acked but never reach the array.
  assign bus.mem_renb  = w_any_gnt && !w_sel_we && !w_misalign;
  assign bus.mem_wenb  = w_any_gnt && w_sel_we && !w_misalign;
  assign bus.mem_webb  = w_webb;
  assign bus.mem_datab = w_datab;
  assign bus.mem_addrb = w_sel_addr[AW-1:2];
  assign bus.dmem_ack  = w_dmem_gnt;
  assign bus.ext_ack   = w_ext_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= OWN_NONE;
      r_err   <= 1'b0;
      r_rd    <= 1'b0;
    end else begin
      r_owner <= w_dmem_gnt ? OWN_DMEM : (w_ext_gnt ? OWN_EXT : OWN_NONE);
      r_err   <= w_any_gnt && w_misalign;
      r_rd    <= w_any_gnt && !w_sel_we && !w_misalign;
    end
  end

`ifdef SCR1_TCM_ARB_STARVE_EN
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  logic [SCW-1:0] r_starve_cnt;

  always_ff @(posedge clk) begin
    if (rst || !bus.ext_req || w_ext_gnt) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != SCW'(STARVE_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + SCW'(1);
    end
  end

  assign w_ext_prio = (r_starve_cnt == SCW'(STARVE_LIMIT));
`else
  assign w_ext_prio = 1'b0;
`endif

  // mem_qb is only meaningful in the cycle after a read enable, so it is
  // steered straight to the owner rather than re-registered.
  assign w_dmem_rsp = !rst && (r_owner == OWN_DMEM);
  assign w_ext_rsp  = !rst && (r_owner == OWN_EXT);
  assign w_rsp_data = r_rd ? bus.mem_qb : 32'h0;

  assign bus.dmem_resp  = w_dmem_rsp;
  assign bus.dmem_err   = w_dmem_rsp && r_err;
  assign bus.dmem_rdata = w_dmem_rsp ? w_rsp_data : 32'h0;
  assign bus.ext_resp   = w_ext_rsp;
  assign bus.ext_err    = w_ext_rsp && r_err;
  assign bus.ext_rdata  = w_ext_rsp ? w_rsp_data : 32'h0;
endmodule
`default_nettype wire

// File: tb/tb_scr1_tcm_dport_arb.sv
`default_nettype none
// Testbench for scr1_tcm_dport_arb: directed scenarios plus randomized traffic
// checked against a byte-addressed memory and arbitration model.
module tb_scr1_tcm_dport_arb;
  localparam int TCM_SIZE     = 32'h00010000;
  localparam int AW           = $clog2(TCM_SIZE);
  localparam int STARVE_LIMIT = 4;
  localparam int NWORDS       = TCM_SIZE / 4;
`ifdef SCR1_TCM_ARB_STARVE_EN
  localparam int EXP_DMEM_ACKS = 9;
  localparam int EXP_EXT_ACKS  = 1;
  localparam int EXP_EXT_CYCLE = 5;
`else
  localparam int EXP_DMEM_ACKS = 10;
  localparam int EXP_EXT_ACKS  = 0;
  localparam int EXP_EXT_CYCLE = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   passes   = 0;
  int   ext_wait = 0;

  always #5 clk = ~clk;

  scr1_tcm_dport_arb_if #(.AW(AW)) bus ();

  scr1_tcm_dport_arb #(
    .TCM_SIZE     (TCM_SIZE),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Port-B SRAM: synchronous, one-cycle read latency, byte-enabled writes.
  logic [31:0] sram [NWORDS];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NWORDS; i++) sram[i] <= 32'h0;
    end else begin
      if (bus.mem_wenb)
        for (int b = 0; b < 4; b++)
          if (bus.mem_webb[b]) sram[bus.mem_addrb][8*b +: 8] <= bus.mem_datab[8*b +: 8];
      if (bus.mem_renb) bus.mem_qb <= sram[bus.mem_addrb];
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [TCM_SIZE];

  function automatic void clear_ref();
    for (int i = 0; i < TCM_SIZE; i++) ref_mem[i] = 8'h0;
  endfunction

  function automatic void model_access(input bit we, input logic [1:0] w, input logic [AW-1:0] a,
                                       input logic [31:0] wd, output bit err, output logic [31:0] rd);
    int n, ai, base;
    ai  = int'(a);
    n   = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    err = (w == 2'd3) || (ai % n != 0);
    rd  = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[ai + i] = wd[8*i +: 8];
      end else begin
        base = ai - (ai % 4);
        for (int i = 0; i < 4; i++) rd[8*i +: 8] = ref_mem[base + i];
      end
    end
  endfunction

  function automatic bit ext_first();
`ifdef SCR1_TCM_ARB_STARVE_EN
    return ext_wait >= STARVE_LIMIT;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void update_wait(input bit ext_req, input bit ext_granted);
    if (ext_req && !ext_granted) ext_wait = (ext_wait < STARVE_LIMIT) ? ext_wait + 1 : ext_wait;
    else                         ext_wait = 0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_dmem(input bit req, input bit we, input logic [1:0] w,
                          input logic [AW-1:0] a, input logic [31:0] d);
    bus.dmem_req = req; bus.dmem_we = we; bus.dmem_width = w; bus.dmem_addr = a; bus.dmem_wdata = d;
  endtask

  task automatic set_ext(input bit req, input bit we, input logic [1:0] w,
                         input logic [AW-1:0] a, input logic [31:0] d);
    bus.ext_req = req; bus.ext_we = we; bus.ext_width = w; bus.ext_addr = a; bus.ext_wdata = d;
  endtask

  task automatic idle(input int n);
    set_dmem(1'b0, 1'b0, 2'd2, '0, 32'h0);
    set_ext(1'b0, 1'b0, 2'd2, '0, 32'h0);
    repeat (n) @(posedge clk);
    #1;
    ext_wait = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_dmem(1'b1, 1'b0, 2'd2, 16'h0010, 32'h0);
    set_ext(1'b1, 1'b1, 2'd2, 16'h0020, 32'h1234);
    #1;
    checks++;
    if (bus.dmem_ack !== 1'b0) $display("FAIL rst_dmem_ack: got %b want 0", bus.dmem_ack); else passes++;
    checks++;
    if (bus.ext_ack !== 1'b0) $display("FAIL rst_ext_ack: got %b want 0", bus.ext_ack); else passes++;
    checks++;
    if ({bus.mem_renb, bus.mem_wenb} !== 2'b00)
      $display("FAIL rst_mem_en: got %b want 00", {bus.mem_renb, bus.mem_wenb}); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    set_dmem(1'b0, 1'b0, 2'd2, '0, 32'h0);
    set_ext(1'b0, 1'b0, 2'd2, '0, 32'h0);
    #1;
    checks++;
    if ({bus.dmem_resp, bus.dmem_err, bus.dmem_rdata} !== 34'h0)
      $display("FAIL rst_dmem_out: got %h want 0", {bus.dmem_resp, bus.dmem_err, bus.dmem_rdata}); else passes++;
    checks++;
    if ({bus.ext_resp, bus.ext_err, bus.ext_rdata} !== 34'h0)
      $display("FAIL rst_ext_out: got %h want 0", {bus.ext_resp, bus.ext_err, bus.ext_rdata}); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_word_rw();
    bit err; logic [31:0] rd;
    set_dmem(1'b1, 1'b1, 2'd2, 16'h0010, 32'hDEADBEEF);
    #1;
    checks++;
    if ({bus.dmem_ack, bus.ext_ack} !== 2'b10)
      $display("FAIL wrw_ack: got %b want 10", {bus.dmem_ack, bus.ext_ack}); else passes++;
    checks++;
    if ({bus.mem_renb, bus.mem_wenb, bus.mem_webb, bus.mem_addrb, bus.mem_datab} !==
        {1'b0, 1'b1, 4'hF, 14'd4, 32'hDEADBEEF})
      $display("FAIL wrw_wr_bus: got en=%b%b webb=%h addrb=%h datab=%h want en=01 webb=f addrb=4 datab=deadbeef",
               bus.mem_renb, bus.mem_wenb, bus.mem_webb, bus.mem_addrb, bus.mem_datab); else passes++;
    model_access(1'b1, 2'd2, 16'h0010, 32'hDEADBEEF, err, rd);
    @(posedge clk); #1;
    checks++;
    if ({bus.dmem_resp, bus.dmem_err, bus.dmem_rdata, bus.ext_resp} !== {1'b1, 1'b0, 32'h0, 1'b0})
      $display("FAIL wrw_wr_resp: got resp=%b err=%b rdata=%h ext_resp=%b want 1 0 0 0",
               bus.dmem_resp, bus.dmem_err, bus.dmem_rdata, bus.ext_resp); else passes++;
    set_dmem(1'b1, 1'b0, 2'd2, 16'h0010, 32'h0);
    #1;
    checks++;
    if ({bus.mem_renb, bus.mem_wenb, bus.mem_addrb} !== {1'b1, 1'b0, 14'd4})
      $display("FAIL wrw_rd_bus: got en=%b%b addrb=%h want 10 4", bus.mem_renb, bus.mem_wenb, bus.mem_addrb);
    else passes++;
    model_access(1'b0, 2'd2, 16'h0010, 32'h0, err, rd);
    @(posedge clk); #1;
    checks++;
    if ({bus.dmem_resp, bus.dmem_err, bus.dmem_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF})
      $display("FAIL wrw_rd_resp: got resp=%b err=%b rdata=%h want 1 0 deadbeef",
               bus.dmem_resp, bus.dmem_err, bus.dmem_rdata); else passes++;
  endtask

  task automatic test_ext_byte();
    bit err; logic [31:0] rd;
    set_ext(1'b1, 1'b1, 2'd0, 16'h0013, 32'h000000A5);
    #1;
    checks++;
    if ({bus.dmem_ack, bus.ext_ack, bus.mem_renb, bus.mem_wenb} !== 4'b0101)
      $display("FAIL eb_ack_en: got %b want 0101", {bus.dmem_ack, bus.ext_ack, bus.mem_renb, bus.mem_wenb});
    else passes++;
    checks++;
    if ({bus.mem_webb, bus.mem_addrb, bus.mem_datab} !== {4'b1000, 14'd4, 32'hA5A5A5A5})
      $display("FAIL eb_wr_bus: got webb=%b addrb=%h datab=%h want 1000 4 a5a5a5a5",
               bus.mem_webb, bus.mem_addrb, bus.mem_datab); else passes++;
    model_access(1'b1, 2'd0, 16'h0013, 32'h000000A5, err, rd);
    @(posedge clk); #1;
    checks++;
    if ({bus.ext_resp, bus.ext_err, bus.ext_rdata, bus.dmem_resp} !== {1'b1, 1'b0, 32'h0, 1'b0})
      $display("FAIL eb_resp: got resp=%b err=%b rdata=%h dmem_resp=%b want 1 0 0 0",
               bus.ext_resp, bus.ext_err, bus.ext_rdata, bus.dmem_resp); else passes++;
    set_ext(1'b0, 1'b0, 2'd2, '0, 32'h0);
    set_dmem(1'b1, 1'b0, 2'd2, 16'h0010, 32'h0);
    model_access(1'b0, 2'd2, 16'h0010, 32'h0, err, rd);
    @(posedge clk); #1;
    checks++;
    if ({bus.dmem_resp, bus.dmem_err, bus.dmem_rdata} !== {1'b1, 1'b0, 32'hA5ADBEEF})
      $display("FAIL eb_raw_read: got resp=%b err=%b rdata=%h want 1 0 a5adbeef",
               bus.dmem_resp, bus.dmem_err, bus.dmem_rdata); else passes++;
  endtask

  task automatic test_errors();
    bit          t_ext [3] = '{1'b0, 1'b0, 1'b1};
    bit          t_we  [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  t_w   [3] = '{2'd1, 2'd2, 2'd3};
    logic [15:0] t_a   [3] = '{16'h0011, 16'h0012, 16'h0020};
    logic [33:0] own, oth;
    for (int k = 0; k < 3; k++) begin
      if (t_ext[k]) begin
        set_dmem(1'b0, 1'b0, 2'd2, '0, 32'h0);
        set_ext(1'b1, t_we[k], t_w[k], t_a[k], 32'h5A5A1234);
      end else begin
        set_ext(1'b0, 1'b0, 2'd2, '0, 32'h0);
        set_dmem(1'b1, t_we[k], t_w[k], t_a[k], 32'h5A5A1234);
      end
      #1;
      checks++;
      if ({bus.dmem_ack, bus.ext_ack, bus.mem_renb, bus.mem_wenb} !== {!t_ext[k], t_ext[k], 2'b00})
        $display("FAIL err_ack_en[%0d]: got %b want %b", k,
                 {bus.dmem_ack, bus.ext_ack, bus.mem_renb, bus.mem_wenb}, {!t_ext[k], t_ext[k], 2'b00});
      else passes++;
      @(posedge clk); #1;
      own = t_ext[k] ? {bus.ext_resp, bus.ext_err, bus.ext_rdata} : {bus.dmem_resp, bus.dmem_err, bus.dmem_rdata};
      oth = t_ext[k] ? {bus.dmem_resp, bus.dmem_err, bus.dmem_rdata} : {bus.ext_resp, bus.ext_err, bus.ext_rdata};
      checks++;
      if ({own, oth} !== {1'b1, 1'b1, 32'h0, 34'h0})
        $display("FAIL err_resp[%0d]: got owner=%h other=%h want owner=300000000 other=0", k, own, oth);
      else passes++;
    end
  endtask

  task automatic test_contention();
    int d_cnt = 0, e_cnt = 0, e_cycle = 0;
    bit e_pend = 1'b1, exp_e;
    set_dmem(1'b1, 1'b0, 2'd2, 16'h0010, 32'h0);
    set_ext(1'b1, 1'b0, 2'd2, 16'h0014, 32'h0);
    for (int c = 1; c <= 10; c++) begin
      exp_e = e_pend && ext_first();
      #1;
      checks++;
      if ({bus.dmem_ack, bus.ext_ack} !== {!exp_e, exp_e})
        $display("FAIL cont_ack[%0d]: got %b want %b", c, {bus.dmem_ack, bus.ext_ack}, {!exp_e, exp_e});
      else passes++;
      if (bus.dmem_ack === 1'b1) d_cnt++;
      if (bus.ext_ack === 1'b1) begin e_cnt++; e_cycle = c; end
      update_wait(e_pend, exp_e);
      @(posedge clk); #1;
      checks++;
      if ({bus.dmem_resp, bus.ext_resp} !== {!exp_e, exp_e})
        $display("FAIL cont_resp[%0d]: got %b want %b", c, {bus.dmem_resp, bus.ext_resp}, {!exp_e, exp_e});
      else passes++;
      if (exp_e) begin
        e_pend = 1'b0;
        set_ext(1'b0, 1'b0, 2'd2, '0, 32'h0);
      end
    end
    checks++;
    if (d_cnt !== EXP_DMEM_ACKS || e_cnt !== EXP_EXT_ACKS || e_cycle !== EXP_EXT_CYCLE)
      $display("FAIL cont_totals: got dmem=%0d ext=%0d ext_cycle=%0d want %0d %0d %0d",
               d_cnt, e_cnt, e_cycle, EXP_DMEM_ACKS, EXP_EXT_ACKS, EXP_EXT_CYCLE);
    else passes++;
  endtask

  task automatic test_alternating();
    bit is_ext, we, err; logic [AW-1:0] a; logic [31:0] d, rd; logic [33:0] own, oth;
    for (int i = 0; i < 12; i++) begin
      is_ext = (i % 2) == 1;
      we     = i < 4;
      a      = AW'(32'h40 + 4 * (i % 4));
      d      = $urandom;
      if (is_ext) begin
        set_dmem(1'b0, 1'b0, 2'd2, '0, 32'h0);
        set_ext(1'b1, we, 2'd2, a, d);
      end else begin
        set_ext(1'b0, 1'b0, 2'd2, '0, 32'h0);
        set_dmem(1'b1, we, 2'd2, a, d);
      end
      #1;
      checks++;
      if ({bus.dmem_ack, bus.ext_ack} !== {!is_ext, is_ext})
        $display("FAIL alt_ack[%0d]: got %b want %b", i, {bus.dmem_ack, bus.ext_ack}, {!is_ext, is_ext});
      else passes++;
      model_access(we, 2'd2, a, d, err, rd);
      @(posedge clk); #1;
      own = is_ext ? {bus.ext_resp, bus.ext_err, bus.ext_rdata} : {bus.dmem_resp, bus.dmem_err, bus.dmem_rdata};
      oth = is_ext ? {bus.dmem_resp, bus.dmem_err, bus.dmem_rdata} : {bus.ext_resp, bus.ext_err, bus.ext_rdata};
      checks++;
      if ({own, oth} !== {1'b1, err, rd, 34'h0})
        $display("FAIL alt_resp[%0d]: got owner=%h other=%h want owner=%h other=0", i, own, oth, {1'b1, err, rd});
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    set_dmem(1'b1, 1'b0, 2'd2, 16'h0040, 32'h0);
    #1;
    checks++;
    if (bus.dmem_ack !== 1'b1) $display("FAIL rmid_ack: got %b want 1", bus.dmem_ack); else passes++;
    @(posedge clk); #1;
    rst = 1'b1;
    set_dmem(1'b0, 1'b0, 2'd2, '0, 32'h0);
    #1;
    checks++;
    if ({bus.dmem_resp, bus.dmem_rdata, bus.ext_resp, bus.ext_rdata} !== 66'h0)
      $display("FAIL rmid_resp: got dmem=%b/%h ext=%b/%h want 0", bus.dmem_resp, bus.dmem_rdata,
               bus.ext_resp, bus.ext_rdata); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_ref();
    ext_wait = 0;
    #1;
    checks++;
    if ({bus.dmem_resp, bus.dmem_err, bus.dmem_rdata, bus.ext_resp, bus.ext_err, bus.ext_rdata,
         bus.dmem_ack, bus.ext_ack, bus.mem_renb, bus.mem_wenb} !== 72'h0)
      $display("FAIL rmid_after: got dmem=%b%b%h ext=%b%b%h want all 0", bus.dmem_resp, bus.dmem_err,
               bus.dmem_rdata, bus.ext_resp, bus.ext_err, bus.ext_rdata); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit dp = 1'b0, ep = 1'b0, dwe = 1'b0, ewe = 1'b0, exp_d, exp_e, g_we, err;
    logic [1:0] dw = 2'd2, ew = 2'd2, g_w;
    logic [AW-1:0] da = '0, ea = '0, g_a;
    logic [31:0] dd = 32'h0, ed = 32'h0, g_d, rd;
    logic [1:0] exp_en;
    logic [33:0] exp_own;
    for (int c = 0; c < 400; c++) begin
      if (!dp && $urandom_range(0, 3) != 0) begin
        dp = 1'b1; dwe = 1'($urandom_range(0, 1)); dw = 2'($urandom_range(0, 3));
        da = AW'($urandom_range(0, 63)); dd = $urandom;
      end
      if (!ep && $urandom_range(0, 1) != 0) begin
        ep = 1'b1; ewe = 1'($urandom_range(0, 1)); ew = 2'($urandom_range(0, 3));
        ea = AW'($urandom_range(0, 63)); ed = $urandom;
      end
      set_dmem(dp, dwe, dw, da, dd);
      set_ext(ep, ewe, ew, ea, ed);
      exp_e = ep && (!dp || ext_first());
      exp_d = dp && !exp_e;
      g_we = exp_e ? ewe : dwe; g_w = exp_e ? ew : dw; g_a = exp_e ? ea : da; g_d = exp_e ? ed : dd;
      err = 1'b0; rd = 32'h0; exp_en = 2'b00;
      if (exp_d || exp_e) begin
        model_access(g_we, g_w, g_a, g_d, err, rd);
        exp_en = err ? 2'b00 : (g_we ? 2'b01 : 2'b10);
      end
      exp_own = {1'b1, err, rd};
      #1;
      checks++;
      if ({bus.dmem_ack, bus.ext_ack, bus.mem_renb, bus.mem_wenb} !== {exp_d, exp_e, exp_en})
        $display("FAIL rnd_ack_en[%0d]: got %b want %b", c,
                 {bus.dmem_ack, bus.ext_ack, bus.mem_renb, bus.mem_wenb}, {exp_d, exp_e, exp_en});
      else passes++;
      update_wait(ep, exp_e);
      @(posedge clk); #1;
      checks++;
      if ({bus.dmem_resp, bus.dmem_err, bus.dmem_rdata} !== (exp_d ? exp_own : 34'h0))
        $display("FAIL rnd_dmem_resp[%0d]: got %h want %h", c, {bus.dmem_resp, bus.dmem_err, bus.dmem_rdata},
                 exp_d ? exp_own : 34'h0);
      else passes++;
      checks++;
      if ({bus.ext_resp, bus.ext_err, bus.ext_rdata} !== (exp_e ? exp_own : 34'h0))
        $display("FAIL rnd_ext_resp[%0d]: got %h want %h", c, {bus.ext_resp, bus.ext_err, bus.ext_rdata},
                 exp_e ? exp_own : 34'h0);
      else passes++;
      if (exp_d) dp = 1'b0;
      if (exp_e) ep = 1'b0;
    end
  endtask

  initial begin
    clear_ref();
    bus.mem_qb = 32'h0;
    test_reset();
    idle(2);
    test_word_rw();
    idle(1);
    test_ext_byte();
    idle(1);
    test_errors();
    idle(1);
    test_contention();
    idle(2);
    test_alternating();
    idle(1);
    test_reset_mid();
    idle(2);
    test_random();
    idle(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/scr1_tcm_dport_arb.md
Name: scr1_tcm_dport_arb

Overview:
- Arbiter/sequencer for TCM port B (read/write port with byte-enable writes).
- Shares port B between two requesters: the core data port (dmem) and an external system master (ext), e.g. debug or DMA.
- Converts width-coded byte-address requests into word address, byte strobes and lane-shifted write data.
- Routes the 1-cycle-latency read data back to the owner of each access.

Parameters:
- TCM_SIZE, 32'h00010000, TCM size in bytes; address width AW = $clog2(TCM_SIZE).
- STARVE_LIMIT, 4, consecutive cycles ext may wait before it takes priority (optional feature only).

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  reset, synchronous, active-high
- dmem_req  in  1  core request valid
- dmem_we  in  1  1=write, 0=read
- dmem_width  in  2  00=byte, 01=half, 10=word, 11=reserved
- dmem_addr  in  AW  byte address
- dmem_wdata  in  32  write data, right-aligned (LSBs)
- dmem_ack  out  1  request accepted this cycle
- dmem_resp  out  1  response valid
- dmem_err  out  1  response is an error (valid with dmem_resp)
- dmem_rdata  out  32  full read word, not shifted
- ext_req, ext_we, ext_width, ext_addr, ext_wdata, ext_ack, ext_resp, ext_err, ext_rdata: same as the dmem_* ports, for the external master
- mem_renb  out  1  port B read enable
- mem_wenb  out  1  port B write enable
- mem_webb  out  4  port B byte enables
- mem_addrb  out  AW-2  port B word address
- mem_datab  out  32  port B write data, lane-shifted
- mem_qb  in  32  port B read data, valid one cycle after mem_renb

Behaviour:
- Reset values:
  - Registered outputs (dmem_resp, dmem_err, dmem_rdata, ext_resp, ext_err, ext_rdata) are 0 the cycle after rst.
  - Owner flop = none; error flop = 0; starve counter = 0.
  - While rst=1: acks = 0 and mem_renb = mem_wenb = 0.
- Grant (combinational, one per cycle):
  - Default fixed priority: dmem over ext.
  - The granted requester sees ack=1 in the same cycle its req=1; the other sees ack=0.
  - A requester holds req and its fields stable until ack.
- Pipelining:
  - Accepts one request every cycle, back-to-back, with no bubbles.
  - The response for a grant in cycle N appears in cycle N+1 only.
  - Owner flop = {dmem, ext, none}, registered at each grant.
- Decode:
  - Byte: any address; webb = 1 << addr[1:0]; datab = {4{wdata[7:0]}}.
  - Half: addr[0] must be 0; webb = 4'b0011 << addr[1:0]; datab = {2{wdata[15:0]}}.
  - Word: addr[1:0] must be 0; webb = 4'b1111; datab = wdata.
  - mem_addrb = addr[AW-1:2].
- Errors:
  - Misaligned address or width=11: the request is still acked, but mem_renb/mem_wenb stay 0.
  - Next cycle: owner resp=1, err=1, rdata=0.
- Memory drive:
  - Read grant: mem_renb=1, mem_wenb=0.
  - Write grant: mem_wenb=1, mem_renb=0.
  - No grant: both 0. mem_addrb/mem_datab/mem_webb are don't-care when not enabled.
- Responses:
  - Read: owner rdata = mem_qb, resp=1, err=0.
  - Write: resp=1, err=0, rdata=0.
  - The non-owner's resp, err and rdata are all 0.
  - The response cannot be stalled; requesters always accept it.
- Read-after-write to the same word in consecutive cycles returns the new data, because port B writes before the following read.
- Reset mid-operation: a response pending for the cycle after rst is discarded; no resp is asserted.

Optional Feature:
- Macro: SCR1_TCM_ARB_STARVE_EN.
- Defined:
  - The starve counter increments each cycle ext_req=1 and ext_ack=0, saturating at STARVE_LIMIT.
  - When counter == STARVE_LIMIT, ext wins the next grant over dmem.
  - The counter clears on any ext_ack or when ext_req=0.
- Not defined:
  - No counter is built and priority is strictly dmem over ext.
  - ext can starve indefinitely under continuous dmem traffic.

Test Plan:
- dmem word write addr 0x10 data 0xDEADBEEF, then word read 0x10 -> mem_webb=4'hF, mem_addrb=4; read resp next cycle with dmem_rdata=0xDEADBEEF, err=0.
- ext byte write addr 0x13 data 0xA5 -> mem_webb=4'b1000, mem_datab=0xA5A5A5A5; subsequent word read 0x10 -> 0xA5ADBEEF.
- dmem half write 0x11 and word read 0x12 -> both acked, no mem enable, err=1 next cycle, rdata=0.
- dmem_req and ext_req held every cycle for 10 cycles:
  - without macro: dmem acked 10 times, ext 0 times;
  - with macro and STARVE_LIMIT=4: ext acked in cycle 5, then dmem resumes.
- Alternating dmem read / ext read back-to-back -> each resp lands only at its owner, one cycle later, with no cross-talk.
- Assert rst the cycle after a granted read -> no resp on either port; all outputs 0 afterwards.
